// File: rtl/cue_shot.sv
// Cue shot controller: charges power while the shoot key is held, fires a velocity on release, then waits for balls to settle.
// Optional registered pullback output guarded by macro CUE_SHOT_PULLBACK_EN (default build ties pullback to 0).
module cue_shot #(
    parameter int POWER_MAX = 15,
    parameter int POWER_DIV = 4,
    parameter int VEL_DIV   = 8
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               start_frame,
    input  logic               shoot_key,
    input  logic [10:0]        ballX,
    input  logic [10:0]        ballY,
    input  logic signed [31:0] farEdgeX,
    input  logic signed [31:0] farEdgeY,
    input  logic               balls_moving,
    input  logic               shot_ack,
    output logic               shot_valid,
    output logic signed [31:0] velX,
    output logic signed [31:0] velY,
    output logic [3:0]         power,
    output logic               cue_enable,
    output logic signed [31:0] pullback
);

    typedef enum logic [2:0] {IDLE, CHARGE, FIRE, WAIT_START, WAIT_STOP} state_t;

    localparam int FW = (POWER_DIV > 1) ? $clog2(POWER_DIV) : 1;
    localparam logic signed [31:0] VDIV = 32'(VEL_DIV);

    state_t             state_q, state_d;
    logic signed [31:0] dx_q, dx_d, dy_q, dy_d;
    logic signed [31:0] velx_q, velx_d, vely_q, vely_d;
    logic [3:0]         power_q, power_d;
    logic [FW-1:0]      frm_q, frm_d;
    logic [2:0]         tmo_q, tmo_d;
    logic signed [31:0] prod_x, prod_y;

    always_comb begin
        state_d = state_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        velx_d  = velx_q;
        vely_d  = vely_q;
        power_d = power_q;
        frm_d   = frm_q;
        tmo_d   = tmo_q;
        prod_x  = dx_q * $signed({28'd0, power_q});
        prod_y  = dy_q * $signed({28'd0, power_q});
        case (state_q)
            IDLE: begin
                power_d = '0;
                frm_d   = '0;
                tmo_d   = '0;
                if (shoot_key && !balls_moving) begin
                    state_d = CHARGE;
                    power_d = 4'd1;
                    dx_d    = $signed({21'd0, ballX}) - farEdgeX;
                    dy_d    = $signed({21'd0, ballY}) - farEdgeY;
                end
            end
            CHARGE: begin
                // Release takes priority over a coincident frame pulse.
                if (!shoot_key) begin
                    state_d = FIRE;
                    velx_d  = prod_x / VDIV;
                    vely_d  = prod_y / VDIV;
                end else if (start_frame) begin
                    if (frm_q == FW'(POWER_DIV - 1)) begin
                        frm_d = '0;
                        if (power_q < 4'(POWER_MAX))
                            power_d = power_q + 4'd1;
                    end else begin
                        frm_d = frm_q + FW'(1);
                    end
                end
            end
            FIRE: begin
                if (shot_ack) begin
                    state_d = WAIT_START;
                    tmo_d   = '0;
                end
            end
            WAIT_START: begin
                if (balls_moving) begin
                    state_d = WAIT_STOP;
                end else if (start_frame) begin
                    if (tmo_q == 3'd7) begin
                        state_d = IDLE;
                        velx_d  = '0;
                        vely_d  = '0;
                        power_d = '0;
                    end else begin
                        tmo_d = tmo_q + 3'd1;
                    end
                end
            end
            WAIT_STOP: begin
                if (!balls_moving) begin
                    state_d = IDLE;
                    velx_d  = '0;
                    vely_d  = '0;
                    power_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            dx_q    <= '0;
            dy_q    <= '0;
            velx_q  <= '0;
            vely_q  <= '0;
            power_q <= '0;
            frm_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            velx_q  <= velx_d;
            vely_q  <= vely_d;
            power_q <= power_d;
            frm_q   <= frm_d;
            tmo_q   <= tmo_d;
        end
    end

    assign shot_valid = (state_q == FIRE);
    assign cue_enable = (state_q == IDLE);
    assign velX       = velx_q;
    assign velY       = vely_q;
    assign power      = power_q;

`ifdef CUE_SHOT_PULLBACK_EN
    logic signed [31:0] pullback_q;

    // Driven from next-state values so the draw offset tracks power on the same edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            pullback_q <= '0;
        else if (state_d == CHARGE || state_d == FIRE)
            pullback_q <= $signed({26'd0, power_d, 2'b00});
        else
            pullback_q <= '0;
    end

    assign pullback = pullback_q;
`else
    assign pullback = '0;
`endif

endmodule

// File: tb/tb_cue_shot.sv
// Scoreboard bench for cue_shot: expected shots queued at release, a forked monitor compares every valid cycle.
module tb_cue_shot;

    logic               clk = 1'b0;
    logic               resetN = 1'b0;
    logic               start_frame = 1'b0;
    logic               shoot_key = 1'b0;
    logic [10:0]        ballX = '0;
    logic [10:0]        ballY = '0;
    logic signed [31:0] farEdgeX = '0;
    logic signed [31:0] farEdgeY = '0;
    logic               balls_moving = 1'b0;
    logic               shot_ack = 1'b0;
    logic               shot_valid;
    logic signed [31:0] velX, velY, pullback;
    logic [3:0]         power;
    logic               cue_enable;

    typedef struct {
        logic signed [31:0] vx;
        logic signed [31:0] vy;
        logic [3:0]         pw;
    } shot_t;

    shot_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    cue_shot dut (
        .clk(clk), .resetN(resetN), .start_frame(start_frame), .shoot_key(shoot_key),
        .ballX(ballX), .ballY(ballY), .farEdgeX(farEdgeX), .farEdgeY(farEdgeY),
        .balls_moving(balls_moving), .shot_ack(shot_ack), .shot_valid(shot_valid),
        .velX(velX), .velY(velY), .power(power), .cue_enable(cue_enable), .pullback(pullback)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        start_frame = 1'b1;
        tick(1);
        start_frame = 1'b0;
        tick(2);
    endtask

    task automatic monitor();
        shot_t cur;
        logic  prev_v;
        prev_v = 1'b0;
        cur.vx = '0; cur.vy = '0; cur.pw = '0;
        forever begin
            @(negedge clk);
            if (!resetN) begin
                prev_v = 1'b0;
            end else begin
                if (shot_valid) begin
                    if (!prev_v) begin
                        if (exp_q.size() == 0)
                            chk("unexpected_shot", {31'd0, shot_valid}, 32'd0);
                        else
                            cur = exp_q.pop_front();
                    end
                    chk("shot_velX", velX, cur.vx);
                    chk("shot_velY", velY, cur.vy);
                    chk("shot_power", {28'd0, power}, {28'd0, cur.pw});
                end
                prev_v = shot_valid;
            end
        end
    endtask

    task automatic expect_shot(input logic signed [31:0] vx, input logic signed [31:0] vy, input logic [3:0] pw);
        shot_t s;
        s.vx = vx; s.vy = vy; s.pw = pw;
        exp_q.push_back(s);
    endtask

    // Ack after a hold period, then let the balls start and stop.
    task automatic ack_and_settle(input int hold);
        tick(hold);
        shot_ack = 1'b1;
        tick(1);
        shot_ack = 1'b0;
        chk("valid_drop_after_ack", {31'd0, shot_valid}, 32'd0);
        balls_moving = 1'b1;
        tick(2);
        chk("cue_locked_while_moving", {31'd0, cue_enable}, 32'd0);
        balls_moving = 1'b0;
        tick(2);
        chk("idle_cue_enable", {31'd0, cue_enable}, 32'd1);
        chk("idle_power", {28'd0, power}, 32'd0);
        chk("idle_velX", velX, 32'd0);
        chk("idle_velY", velY, 32'd0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        tick(3);
        chk("rst_shot_valid", {31'd0, shot_valid}, 32'd0);
        chk("rst_velX", velX, 32'd0);
        chk("rst_velY", velY, 32'd0);
        chk("rst_power", {28'd0, power}, 32'd0);
        chk("rst_cue_enable", {31'd0, cue_enable}, 32'd1);
        chk("rst_pullback", pullback, 32'd0);
        resetN = 1'b1;
        tick(2);

        // Power ramp: dx=128, 16 frames -> power 5, velX 80; farEdge moves after latch
        ballX = 11'd320; ballY = 11'd240; farEdgeX = 192; farEdgeY = 240;
        shoot_key = 1'b1;
        tick(1);
        farEdgeX = 0; farEdgeY = -500;
        chk("charge_power_start", {28'd0, power}, 32'd1);
        chk("charge_cue_disabled", {31'd0, cue_enable}, 32'd0);
        repeat (16) frame();
        chk("ramp_power", {28'd0, power}, 32'd5);
        expect_shot(32'sd80, 32'sd0, 4'd5);
        shoot_key = 1'b0;
        tick(1);
        chk("ramp_shot_valid", {31'd0, shot_valid}, 32'd1);
        shoot_key = 1'b1;
        frame();
        chk("fire_ignores_key_power", {28'd0, power}, 32'd5);
        shoot_key = 1'b0;
        ack_and_settle(50);

        // Truncation plus release coinciding with a power wrap frame
        ballX = 11'd100; ballY = 11'd0; farEdgeX = 145; farEdgeY = 0;
        shoot_key = 1'b1;
        tick(1);
        repeat (3) frame();
        expect_shot(-32'sd5, 32'sd0, 4'd1);
        start_frame = 1'b1;
        shoot_key = 1'b0;
        tick(1);
        start_frame = 1'b0;
        chk("release_wins_power", {28'd0, power}, 32'd1);
        tick(3);
        shot_ack = 1'b1;
        tick(1);
        shot_ack = 1'b0;
        chk("trunc_valid_drop", {31'd0, shot_valid}, 32'd0);

        // Timeout: balls never move
        repeat (7) frame();
        chk("timeout_not_yet", {31'd0, cue_enable}, 32'd0);
        frame();
        chk("timeout_idle", {31'd0, cue_enable}, 32'd1);
        chk("timeout_velX", velX, 32'd0);
        chk("timeout_power", {28'd0, power}, 32'd0);

        // Saturation: dy=128, 100 frames -> power 15, velY 240
        ballX = 11'd200; ballY = 11'd128; farEdgeX = 200; farEdgeY = 0;
        shoot_key = 1'b1;
        tick(1);
        repeat (100) frame();
        chk("sat_power", {28'd0, power}, 32'd15);
`ifdef CUE_SHOT_PULLBACK_EN
        chk("sat_pullback", pullback, 32'd60);
`else
        chk("sat_pullback", pullback, 32'd0);
`endif
        expect_shot(32'sd0, 32'sd240, 4'd15);
        shoot_key = 1'b0;
        tick(1);
        ack_and_settle(4);

        // Lockout: key ignored while balls move; ack outside FIRE ignored
        balls_moving = 1'b1;
        shoot_key = 1'b1;
        shot_ack = 1'b1;
        tick(3);
        shot_ack = 1'b0;
        chk("lockout_cue_enable", {31'd0, cue_enable}, 32'd1);
        chk("lockout_power", {28'd0, power}, 32'd0);
        shoot_key = 1'b0;
        balls_moving = 1'b0;
        tick(2);

        // Async reset mid-charge at power 7
        ballX = 11'd320; ballY = 11'd240; farEdgeX = 192; farEdgeY = 240;
        shoot_key = 1'b1;
        tick(1);
        repeat (24) frame();
        chk("pre_reset_power", {28'd0, power}, 32'd7);
        resetN = 1'b0;
        #1;
        chk("async_rst_power", {28'd0, power}, 32'd0);
        chk("async_rst_cue_enable", {31'd0, cue_enable}, 32'd1);
        shoot_key = 1'b0;
        tick(2);
        resetN = 1'b1;
        tick(10);
        chk("post_reset_no_shot", {31'd0, shot_valid}, 32'd0);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
